// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 block: register numbers, bit positions,
// exception codes and the EPC computation used on trap entry.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 8;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int IP_TIMER     = 7;
  localparam int IP_HW_LO     = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Restart address: a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_calc(input logic [29:0] pc_word, input logic bd);
    logic [31:0] base;
    base = {pc_word, 2'b00};
    return bd ? (base - 32'd4) : base;
  endfunction

  function automatic logic [31:0] sr_word(input logic ie, input logic exl, input logic [7:0] im);
    return {16'h0000, im, 6'b000000, exl, ie};
  endfunction

  function automatic logic [31:0] cause_word(input logic bd, input logic [7:0] ip, input logic [4:0] exc);
    return {bd, 15'h0000, ip, 1'b0, exc, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer_if.sv
// Pipeline-side bus of CP0: mtc0/mfc0 access, M-stage exception info,
// interrupt lines and the trap/eret return path.
interface cp0_timer_if #(
  parameter int NUM_HWINT = 5
);
  logic                 we;
  logic [4:0]           wr_addr;
  logic [31:0]          din;
  logic [4:0]           rd_addr;
  logic [31:0]          dout;
  logic [31:0]          pc;
  logic                 bd;
  logic                 exc_valid;
  logic [4:0]           exc_code;
  logic [31:0]          bad_vaddr;
  logic [NUM_HWINT-1:0] hw_int;
  logic                 eret;
  logic                 trap;
  logic [31:0]          epc_out;
  logic                 exl_out;

  modport master (
    output we, wr_addr, din, rd_addr, pc, bd, exc_valid, exc_code,
           bad_vaddr, hw_int, eret,
    input  dout, trap, epc_out, exl_out
  );

  modport slave (
    input  we, wr_addr, din, rd_addr, pc, bd, exc_valid, exc_code,
           bad_vaddr, hw_int, eret,
    output dout, trap, epc_out, exl_out
  );
endinterface

// File: rtl/cp0_timer_unit.sv
// Count/Compare timer: prescaled Count, Compare, and the sticky timer
// interrupt flag. When disabled, all outputs read as zero.
module cp0_timer_unit #(
  parameter bit TIMER_EN  = 1'b1,
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_r;
  logic [31:0]   count_r;
  logic [31:0]   compare_r;
  logic          ti_r;
  logic          eq_d_r;
  logic          tick_s;
  logic          eq_s;

  assign tick_s = (presc_r == PRESC_MAX);
  assign eq_s   = (count_r == compare_r);

  // Prescaler and Count; an mtc0 to Count restarts the prescale period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
      count_r <= 32'h0000_0000;
    end else if (count_we) begin
      presc_r <= '0;
      count_r <= din;
    end else if (tick_s) begin
      presc_r <= '0;
      count_r <= count_r + 32'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Compare register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare_r <= 32'h0000_0000;
    end else if (compare_we) begin
      compare_r <= din;
    end
  end

  // TI fires on the rising edge of Count==Compare. The edge history resets
  // high because both registers come out of reset equal, which must not
  // count as a match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eq_d_r <= 1'b1;
      ti_r   <= 1'b0;
    end else begin
      eq_d_r <= eq_s;
      if (compare_we) begin
        ti_r <= 1'b0;
      end else if (eq_s && !eq_d_r) begin
        ti_r <= 1'b1;
      end
    end
  end

  assign count   = TIMER_EN ? count_r   : 32'h0000_0000;
  assign compare = TIMER_EN ? compare_r : 32'h0000_0000;
  assign ti      = TIMER_EN ? ti_r      : 1'b0;

endmodule

// File: rtl/cp0_timer.sv
// System coprocessor 0: SR/Cause/EPC/BadVAddr/PRId plus Count/Compare timer,
// interrupt prioritisation and the single trap request to the pipeline.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 5,
  parameter bit          TIMER_EN  = 1'b1,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] PRID      = 32'h0001_8000
) (
  input  logic       clk,
  input  logic       reset_n,
  cp0_timer_if.slave bus
);

  logic                 sr_ie_r;
  logic                 sr_exl_r;
  logic [7:0]           sr_im_r;
  logic                 cause_bd_r;
  logic [1:0]           cause_sw_r;
  logic [NUM_HWINT-1:0] cause_hw_r;
  logic [4:0]           cause_exc_r;
  logic [31:0]          epc_r;
  logic [31:0]          badvaddr_r;

  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        ti_s;
  logic [7:0]  ip_s;
  logic [7:0]  pend_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        trap_s;
  logic        load_bva_s;
  logic        wr_sr_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic [31:0] dout_s;
  logic        unused_pc_s;

  assign unused_pc_s = ^bus.pc[1:0];

  assign wr_sr_s      = bus.we && (bus.wr_addr == REG_SR);
  assign wr_cause_s   = bus.we && (bus.wr_addr == REG_CAUSE);
  assign wr_epc_s     = bus.we && (bus.wr_addr == REG_EPC);
  assign wr_count_s   = bus.we && (bus.wr_addr == REG_COUNT);
  assign wr_compare_s = bus.we && (bus.wr_addr == REG_COMPARE);

  cp0_timer_unit #(
    .TIMER_EN  (TIMER_EN),
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_we   (wr_count_s),
    .compare_we (wr_compare_s),
    .din        (bus.din),
    .count      (count_s),
    .compare    (compare_s),
    .ti         (ti_s)
  );

  // Assemble Cause.IP from software bits, sampled hardware lines and TI.
  always_comb begin
    ip_s = 8'h00;
    ip_s[1:0] = cause_sw_r;
    for (int i = 0; i < NUM_HWINT; i++) begin
      ip_s[IP_HW_LO + i] = cause_hw_r[i];
    end
    ip_s[IP_TIMER] = ti_s;
  end

  assign pend_s     = ip_s & sr_im_r;
  assign int_req_s  = sr_ie_r && !sr_exl_r && (|pend_s);
  assign exc_req_s  = bus.exc_valid && !sr_exl_r;
  assign trap_s     = int_req_s || exc_req_s;
  assign load_bva_s = trap_s && !int_req_s &&
                      ((bus.exc_code == EXC_ADEL) || (bus.exc_code == EXC_ADES));

  // SR: trap entry beats eret, which beats a plain mtc0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_ie_r  <= 1'b0;
      sr_exl_r <= 1'b0;
      sr_im_r  <= 8'h00;
    end else if (trap_s) begin
      sr_exl_r <= 1'b1;
    end else if (bus.eret) begin
      sr_exl_r <= 1'b0;
    end else if (wr_sr_s) begin
      sr_ie_r  <= bus.din[SR_IE];
      sr_exl_r <= bus.din[SR_EXL];
      sr_im_r  <= bus.din[SR_IM_LO +: 8];
    end
  end

  // Cause: hardware lines sampled every cycle; trap beats the software-bit write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_hw_r  <= '0;
      cause_bd_r  <= 1'b0;
      cause_sw_r  <= 2'b00;
      cause_exc_r <= 5'd0;
    end else begin
      cause_hw_r <= bus.hw_int;
      if (trap_s) begin
        cause_bd_r  <= bus.bd;
        cause_exc_r <= int_req_s ? EXC_INT : bus.exc_code;
      end else if (wr_cause_s) begin
        cause_sw_r <= bus.din[CAUSE_IP_LO +: 2];
      end
    end
  end

  // EPC: trap beats mtc0; the low two bits are always stored as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc_r <= 32'h0000_0000;
    end else if (trap_s) begin
      epc_r <= epc_calc(bus.pc[31:2], bus.bd);
    end else if (wr_epc_s) begin
      epc_r <= {bus.din[31:2], 2'b00};
    end
  end

  // BadVAddr only captures address-error exceptions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      badvaddr_r <= 32'h0000_0000;
    end else if (load_bva_s) begin
      badvaddr_r <= bus.bad_vaddr;
    end
  end

  // mfc0 read mux; returns pre-write state.
  always_comb begin
    dout_s = 32'h0000_0000;
    case (bus.rd_addr)
      REG_BADVADDR: dout_s = badvaddr_r;
      REG_COUNT:    dout_s = count_s;
      REG_COMPARE:  dout_s = compare_s;
      REG_SR:       dout_s = sr_word(sr_ie_r, sr_exl_r, sr_im_r);
      REG_CAUSE:    dout_s = cause_word(cause_bd_r, ip_s, cause_exc_r);
      REG_EPC:      dout_s = epc_r;
      REG_PRID:     dout_s = PRID;
      default:      dout_s = 32'h0000_0000;
    endcase
  end

  assign bus.dout    = dout_s;
  assign bus.trap    = trap_s;
  assign bus.epc_out = epc_r;
  assign bus.exl_out = sr_exl_r;

endmodule

// File: tb/tb_cp0_timer.sv
// Directed self-checking bench for cp0_timer with hand-computed expectations.
module tb_cp0_timer;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  cp0_timer_if #(.NUM_HWINT(5)) bus ();

  cp0_timer #(
    .NUM_HWINT (5),
    .TIMER_EN  (1'b1),
    .COUNT_DIV (2),
    .PRID      (32'h0001_8000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rd_addr = addr;
    #1;
    check(tag, bus.dout, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus.we      = 1'b1;
    bus.wr_addr = addr;
    bus.din     = data;
    step();
    bus.we      = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n       = 1'b0;
    bus.we        = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.din       = 32'h0;
    bus.rd_addr   = 5'd0;
    bus.pc        = 32'h0;
    bus.bd        = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_code  = 5'd0;
    bus.bad_vaddr = 32'h0;
    bus.hw_int    = 5'b00000;
    bus.eret      = 1'b0;

    // Reset state
    #2;
    rd("rst_r0", 5'd0, 32'h0);
    rd("rst_badvaddr", 5'd8, 32'h0);
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_compare", 5'd11, 32'h0);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h0001_8000);
    check("rst_trap", {31'h0, bus.trap}, 32'h0);
    check("rst_epc_out", bus.epc_out, 32'h0);
    check("rst_exl", {31'h0, bus.exl_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Hardware interrupt on line 0 (IM bit 10)
    wr(5'd12, 32'h0000_0401);
    rd("sr_write", 5'd12, 32'h0000_0401);
    bus.hw_int = 5'b00001;
    bus.pc     = 32'h0000_3010;
    bus.bd     = 1'b0;
    step();
    check("hw_trap", {31'h0, bus.trap}, 32'h1);
    step();
    check("hw_trap_drop", {31'h0, bus.trap}, 32'h0);
    check("hw_epc", bus.epc_out, 32'h0000_3010);
    check("hw_exl", {31'h0, bus.exl_out}, 32'h1);
    rd("hw_cause", 5'd13, 32'h0000_0400);
    bus.hw_int = 5'b00000;
    bus.eret   = 1'b1;
    step();
    bus.eret = 1'b0;
    check("eret1_exl", {31'h0, bus.exl_out}, 32'h0);
    check("eret1_trap", {31'h0, bus.trap}, 32'h0);

    // Address-error exception in a delay slot
    bus.exc_valid = 1'b1;
    bus.exc_code  = 5'd4;
    bus.bad_vaddr = 32'h0000_1003;
    bus.pc        = 32'h0000_3020;
    bus.bd        = 1'b1;
    #1;
    check("exc_trap", {31'h0, bus.trap}, 32'h1);
    step();
    bus.exc_valid = 1'b0;
    bus.bd        = 1'b0;
    check("exc_epc", bus.epc_out, 32'h0000_301C);
    rd("exc_cause", 5'd13, 32'h8000_0010);
    rd("exc_badvaddr", 5'd8, 32'h0000_1003);
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;

    // Only the software IP bits are writable
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_sw_mask", 5'd13, 32'h8000_0310);
    check("sw_masked_trap", {31'h0, bus.trap}, 32'h0);

    // Interrupt and overflow exception together: interrupt wins
    wr(5'd12, 32'h0000_0101);
    check("sw_trap", {31'h0, bus.trap}, 32'h1);
    bus.exc_valid = 1'b1;
    bus.exc_code  = 5'd12;
    bus.bad_vaddr = 32'hDEAD_BEEF;
    bus.pc        = 32'h0000_3040;
    step();
    bus.exc_valid = 1'b0;
    rd("both_cause", 5'd13, 32'h0000_0300);
    rd("both_badvaddr", 5'd8, 32'h0000_1003);
    check("both_epc", bus.epc_out, 32'h0000_3040);
    wr(5'd13, 32'h0000_0000);
    rd("cause_sw_clear", 5'd13, 32'h0000_0000);
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    check("eret2_exl", {31'h0, bus.exl_out}, 32'h0);

    // EPC low bits, unmapped and read-only registers
    wr(5'd14, 32'h1234_5677);
    check("epc_align", bus.epc_out, 32'h1234_5674);
    wr(5'd3, 32'hFFFF_FFFF);
    rd("unmapped", 5'd3, 32'h0);
    wr(5'd15, 32'h0);
    rd("prid_ro", 5'd15, 32'h0001_8000);
    wr(5'd8, 32'hFFFF_FFFF);
    rd("badvaddr_ro", 5'd8, 32'h0000_1003);

    // Timer: Compare=5, Count=0, prescale by 2
    wr(5'd9, 32'h0000_0100);
    wr(5'd11, 32'h0000_0005);
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'h0000_0000);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("tmr_quiet", {31'h0, bus.trap}, 32'h0);
    end
    rd("tmr_count4", 5'd9, 32'h0000_0004);
    step();
    rd("tmr_count5", 5'd9, 32'h0000_0005);
    check("tmr_not_yet", {31'h0, bus.trap}, 32'h0);
    step();
    check("tmr_trap", {31'h0, bus.trap}, 32'h1);
    rd("tmr_ip7", 5'd13, 32'h0000_8000);
    step();
    check("tmr_exl", {31'h0, bus.exl_out}, 32'h1);
    check("tmr_trap_drop", {31'h0, bus.trap}, 32'h0);
    wr(5'd11, 32'h0000_0064);
    rd("tmr_ip7_clear", 5'd13, 32'h0000_0000);
    rd("tmr_compare", 5'd11, 32'h0000_0064);

    // eret racing an mtc0 to SR
    wr(5'd12, 32'h0000_0003);
    rd("sr_pre_eret", 5'd12, 32'h0000_0003);
    bus.eret    = 1'b1;
    bus.we      = 1'b1;
    bus.wr_addr = 5'd12;
    bus.din     = 32'h0000_0003;
    step();
    bus.eret = 1'b0;
    bus.we   = 1'b0;
    rd("eret_race_sr", 5'd12, 32'h0000_0001);
    check("eret_race_epc", bus.epc_out, 32'h0000_3040);
    check("eret_race_trap", {31'h0, bus.trap}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
